rr_mux_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the shared 4:1 select mux. It collects four request lines and grants the single output channel to one requester at a time. It drives the mux selects `s0`/`s1` from the granted index and forces a release after a bounded hold time. It sits between the four source channels and the downstream single-bit consumer, and it instantiates the select mux itself.

---
 rtl/rr_mux_arbiter_pkg.sv | 46 ++++
 rtl/rr_mux_arbiter_sel_mux4.sv | 22 ++
 rtl/rr_mux_arbiter.sv | 114 +++++++++++
 tb/tb_rr_mux_arbiter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
// Holds the FSM state encoding, channel count, select encoding and round-robin pick.
package arb_pkg;

    localparam int NUM_CH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } pick_t;

    // Returns {s0, s1}; s0 is the MSB of the channel index.
    function automatic logic [1:0] sel_encode(input logic [1:0] idx);
        logic [1:0] sel;
        case (idx)
            2'd0:    sel = 2'b00;
            2'd1:    sel = 2'b01;
            2'd2:    sel = 2'b10;
            default: sel = 2'b11;
        endcase
        return sel;
    endfunction

    // First set request searching upward from ptr with wrap. Scanning from the
    // far end and overwriting lets the closest candidate to ptr win.
    function automatic pick_t rr_pick(input logic [NUM_CH-1:0] req, input logic [1:0] ptr);
        pick_t      p;
        logic [1:0] k;
        p = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            k = ptr + 2'(i);
            if (req[k]) begin
                p.found = 1'b1;
                p.idx   = k;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_sel_mux4.sv
// Combinational 4:1 select: {s0,s1} = 00/01/10/11 picks din[0..3].
// Zero latency, no flow control.
module sel_mux4
    import arb_pkg::*;
(
    input  logic [NUM_CH-1:0] din,
    input  logic              s0,
    input  logic              s1,
    output logic              y
);

    always_comb begin
        y = 1'b0;
        case ({s0, s1})
            2'b00:   y = din[0];
            2'b01:   y = din[1];
            2'b10:   y = din[2];
            default: y = din[3];
        endcase
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving the shared 4:1 select mux, with bounded hold time.
// Grant one cycle after a sampled request; owner is never preempted, one dead TURN cycle between grants.
module rr_mux_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic [NUM_CH-1:0] din,
    output logic [NUM_CH-1:0] gnt,
    output logic              s0,
    output logic              s1,
    output logic              busy,
    output logic              expired,
    output logic              dout
);

    localparam int              HW       = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0]   HOLD_LIM = HW'(MAX_HOLD);

    state_t            state, state_next;
    logic [1:0]        ptr, ptr_next;
    logic [1:0]        owner, owner_next;
    logic [HW-1:0]     hold_cnt, hold_next;
    logic [NUM_CH-1:0] gnt_next;
    logic [1:0]        sel_next;
    logic              busy_next;
    logic              expired_next;
    logic              forced;
    logic              mux_y;
    pick_t             pick;

    always_comb begin
        pick         = rr_pick(req, ptr);
        forced       = (MAX_HOLD != 0) && (hold_cnt == HOLD_LIM) && req[owner];
        state_next   = state;
        ptr_next     = ptr;
        owner_next   = owner;
        hold_next    = hold_cnt;
        expired_next = 1'b0;

        case (state)
            IDLE, TURN: begin
                if (pick.found) begin
                    state_next = GRANT;
                    owner_next = pick.idx;
                    hold_next  = HW'(1);
                end else begin
                    state_next = IDLE;
                    hold_next  = '0;
                end
            end
            GRANT: begin
                if (!req[owner] || forced) begin
                    state_next   = TURN;
                    ptr_next     = owner + 2'd1;
                    hold_next    = '0;
                    expired_next = forced;
                end else if (hold_cnt != '1) begin
                    hold_next = hold_cnt + HW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                hold_next  = '0;
            end
        endcase

        // Outputs are registered copies of what the next state implies.
        gnt_next  = '0;
        sel_next  = 2'b00;
        busy_next = (state_next == GRANT);
        if (busy_next) begin
            gnt_next[owner_next] = 1'b1;
            sel_next             = sel_encode(owner_next);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= 2'd0;
            owner    <= 2'd0;
            hold_cnt <= '0;
            gnt      <= '0;
            s0       <= 1'b0;
            s1       <= 1'b0;
            busy     <= 1'b0;
            expired  <= 1'b0;
        end else begin
            state    <= state_next;
            ptr      <= ptr_next;
            owner    <= owner_next;
            hold_cnt <= hold_next;
            gnt      <= gnt_next;
            s0       <= sel_next[1];
            s1       <= sel_next[0];
            busy     <= busy_next;
            expired  <= expired_next;
        end
    end

    sel_mux4 u_mux (
        .din (din),
        .s0  (s0),
        .s1  (s1),
        .y   (mux_y)
    );

    assign dout = busy & mux_y;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter with MAX_HOLD = 4.
module tb_rr_mux_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] din;
    logic [3:0] gnt;
    logic       s0;
    logic       s1;
    logic       busy;
    logic       expired;
    logic       dout;

    int checks = 0;
    int errors = 0;

    rr_mux_arbiter #(.MAX_HOLD(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .din     (din),
        .gnt     (gnt),
        .s0      (s0),
        .s1      (s1),
        .busy    (busy),
        .expired (expired),
        .dout    (dout)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // {s0, s1, busy, expired, dout}
    function automatic logic [4:0] stat();
        return {s0, s1, busy, expired, dout};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] ix;
        logic [3:0] exp_g;

        rst_n = 1'b0;
        req   = 4'b1111;
        din   = 4'b1111;
        tick;
        tick;
        chk("rst_gnt", 8'(gnt), 8'h00);
        chk("rst_stat", 8'(stat()), 8'h00);

        rst_n = 1'b1;
        req   = 4'b0000;
        tick;
        tick;
        chk("idle_gnt", 8'(gnt), 8'h00);
        chk("idle_busy", 8'(busy), 8'h00);

        // Voluntary transfer on channel 2 for three cycles.
        req = 4'b0100;
        din = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            tick;
            chk("vol_gnt", 8'(gnt), 8'b0100);
            chk("vol_stat", 8'(stat()), 8'b10101);
        end
        req = 4'b0000;
        #1;
        chk("vol_dout_after_drop", 8'(dout), 8'h01);
        tick;
        chk("vol_turn_gnt", 8'(gnt), 8'h00);
        chk("vol_turn_stat", 8'(stat()), 8'h00);
        tick;
        chk("vol_idle_gnt", 8'(gnt), 8'h00);

        // ptr is now 3: full request picks channel 3 first.
        req = 4'b1111;
        din = 4'b1000;
        tick;
        chk("ptr3_gnt", 8'(gnt), 8'b1000);
        chk("ptr3_stat", 8'(stat()), 8'b11101);
        req = 4'b0000;
        tick;
        tick;

        // Forced release on channel 0, two rounds (ptr is 0).
        req = 4'b0001;
        din = 4'b0001;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 4; c++) begin
                tick;
                chk("frc_gnt", 8'(gnt), 8'b0001);
                chk("frc_stat", 8'(stat()), 8'b00101);
            end
            tick;
            chk("frc_turn_gnt", 8'(gnt), 8'h00);
            chk("frc_turn_stat", 8'(stat()), 8'b00010);
        end
        req = 4'b0000;
        tick;
        chk("frc_idle_gnt", 8'(gnt), 8'h00);
        chk("frc_idle_stat", 8'(stat()), 8'h00);

        // No preemption: channel 2 owns while channel 0 also requests (ptr is 1).
        req = 4'b0100;
        din = 4'b0001;
        tick;
        chk("np_gnt0", 8'(gnt), 8'b0100);
        chk("np_stat0", 8'(stat()), 8'b10100);
        req = 4'b0101;
        tick;
        chk("np_gnt1", 8'(gnt), 8'b0100);
        tick;
        chk("np_gnt2", 8'(gnt), 8'b0100);
        req = 4'b0001;
        tick;
        chk("np_turn_gnt", 8'(gnt), 8'h00);
        chk("np_turn_stat", 8'(stat()), 8'h00);
        tick;
        chk("np_next_gnt", 8'(gnt), 8'b0001);
        chk("np_next_stat", 8'(stat()), 8'b00101);

        // Async reset between edges while channel 0 owns; ptr (3) must return to 0.
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_gnt", 8'(gnt), 8'h00);
        chk("ar_stat", 8'(stat()), 8'h00);
        req = 4'b1010;
        tick;
        rst_n = 1'b1;
        tick;
        chk("ar_regrant_gnt", 8'(gnt), 8'b0010);
        chk("ar_regrant_stat", 8'(stat()), 8'b01100);

        // Fair rotation from reset with all channels requesting.
        rst_n = 1'b0;
        req   = 4'b1111;
        din   = 4'b1010;
        tick;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            ix    = 2'(k % 4);
            exp_g = 4'b0001 << ix;
            for (int c = 0; c < 4; c++) begin
                tick;
                chk("rot_gnt", 8'(gnt), 8'(exp_g));
                chk("rot_stat", 8'(stat()), 8'({ix, 1'b1, 1'b0, din[ix]}));
            end
            tick;
            chk("rot_turn_gnt", 8'(gnt), 8'h00);
            chk("rot_turn_stat", 8'(stat()), 8'b00010);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
